// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, FSM states and helpers
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_t;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;
   localparam int START_IDX  = 0;
   localparam int STOP_IDX   = 9;

   localparam int DEF_CLK = 50_000_000;
   localparam int DEF_BPS = 9600;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte bundle of the UART receiver
interface uart_rx_if;
   logic       din;
   logic [7:0] dout;
   logic       dout_vld;
   logic       frame_err;

   modport master (input din, output dout, output dout_vld, output frame_err);
   modport slave  (output din, input dout, input dout_vld, input frame_err);
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; UART_RX_MAJORITY_EN selects 2-of-3 bit sampling
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK     = DEF_CLK,
   parameter int BPS     = DEF_BPS,
   parameter int BPS_CNT = CLK / BPS
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_rx_if.master bus
);
   localparam int CW = $clog2(BPS_CNT);
   localparam logic [CW-1:0] H    = CW'(BPS_CNT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);

   uart_state_t   state;
   logic [CW-1:0] cnt0;
   logic [3:0]    cnt1;
   logic [7:0]    shreg;
   logic [7:0]    dout_q;
   logic          vld_q;
   logic          err_q;
   logic          rx_s;
   logic          rx_d;
   logic          start_edge;
   logic          wrap;
   logic          decide;
   logic          bit_val;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.din),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_d <= 1'b1;
      else        rx_d <= rx_s;
   end

   assign start_edge = rx_d & ~rx_s;
   assign wrap       = (cnt0 == LAST);

`ifdef UART_RX_MAJORITY_EN
   logic samp_a;
   logic samp_b;

   // Early samples at H-1 and H; the third is the live line at H+1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_a <= 1'b1;
         samp_b <= 1'b1;
      end else begin
         if (cnt0 == H - 1'b1) samp_a <= rx_s;
         if (cnt0 == H)        samp_b <= rx_s;
      end
   end

   assign decide  = (cnt0 == H + 1'b1);
   assign bit_val = maj3(samp_a, samp_b, rx_s);
`else
   assign decide  = (cnt0 == H);
   assign bit_val = rx_s;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt0   <= '0;
         cnt1   <= '0;
         shreg  <= '0;
         dout_q <= '0;
         vld_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         err_q <= 1'b0;
         if (state != ST_IDLE) cnt0 <= wrap ? '0 : cnt0 + 1'b1;
         case (state)
            ST_IDLE: begin
               cnt0 <= '0;
               cnt1 <= '0;
               if (start_edge) state <= ST_START;
            end
            ST_START: begin
               if (decide && bit_val) begin
                  state <= ST_IDLE;
                  cnt0  <= '0;
               end else if (wrap) begin
                  cnt1  <= cnt1 + 1'b1;
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (decide) shreg <= {bit_val, shreg[7:1]};
               if (wrap) begin
                  cnt1 <= cnt1 + 1'b1;
                  if (cnt1 == 4'(DATA_BITS)) state <= ST_STOP;
               end
            end
            ST_STOP: begin
               // Leave at mid-stop so a shortened stop bit cannot swallow the next start.
               if (decide) begin
                  if (bit_val) begin
                     dout_q <= shreg;
                     vld_q  <= 1'b1;
                  end else begin
                     err_q  <= 1'b1;
                  end
                  state <= ST_IDLE;
                  cnt0  <= '0;
                  cnt1  <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.dout      = dout_q;
   assign bus.dout_vld  = vld_q;
   assign bus.frame_err = err_q;
endmodule
